// File: rtl/spc_pkg.sv
// Shared types and constants for the safe-PC checkpoint ring.
package spc_pkg;

    typedef enum logic {
        SPC_IDLE,
        SPC_ROLLBACK
    } spc_state_e;

    localparam logic [31:0] SPC_BOOT_ADDR = 32'h0000_0000;

    function automatic int unsigned spc_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/spc_ring_mem.sv
// Checkpoint storage: one synchronous write port, two asynchronous read ports.
module spc_ring_mem
    import spc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [spc_ptr_w(DEPTH)-1:0]   waddr,
    input  logic [ADDR_WIDTH-1:0]         wdata,
    input  logic [spc_ptr_w(DEPTH)-1:0]   raddr_new,
    output logic [ADDR_WIDTH-1:0]         rdata_new,
    input  logic [spc_ptr_w(DEPTH)-1:0]   raddr_sel,
    output logic [ADDR_WIDTH-1:0]         rdata_sel
);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];

    // Storage needs no reset: count gates every use of an entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_new = mem[raddr_new];
    assign rdata_sel = mem[raddr_sel];

endmodule

// File: rtl/spc_ring.sv
// Circular history of safe-PC checkpoints with k-deep rollback handshake.
//   state        | meaning
//   SPC_IDLE     | tracking PC, accepting commits and rollback requests
//   SPC_ROLLBACK | rb_pc_o presented, waiting for rb_ack_i
module spc_ring
    import spc_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = ADDR_WIDTH'(SPC_BOOT_ADDR)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         pc_i,
    input  logic                          pc_valid_i,
    input  logic                          commit_i,
    input  logic                          rollback_i,
    input  logic [spc_ptr_w(DEPTH)-1:0]   rb_depth_i,
    output logic                          rb_valid_o,
    output logic [ADDR_WIDTH-1:0]         rb_pc_o,
    input  logic                          rb_ack_i,
    output logic [ADDR_WIDTH-1:0]         spc_o,
    output logic [spc_ptr_w(DEPTH):0]     count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          err_o,
    output logic                          drop_o
);

    localparam int unsigned PW = spc_ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;

    spc_state_e            state;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [PW-1:0]         sel_depth;
    logic [ADDR_WIDTH-1:0] last_pc_q;
    logic [ADDR_WIDTH-1:0] tracked_pc;
    logic [ADDR_WIDTH-1:0] newest_pc;
    logic [ADDR_WIDTH-1:0] sel_pc;
    logic [PW-1:0]         newest_idx;
    logic [PW-1:0]         sel_idx;
    logic                  rb_legal;
    logic                  mem_we;

    assign tracked_pc = pc_valid_i ? pc_i : last_pc_q;
    assign newest_idx = wr_ptr - PW'(1);
    assign sel_idx    = wr_ptr - PW'(1) - rb_depth_i;
    assign rb_legal   = {1'b0, rb_depth_i} < count;
    assign mem_we     = !rst && (state == SPC_IDLE) && commit_i && !rollback_i;

    spc_ring_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk       (clk),
        .we        (mem_we),
        .waddr     (wr_ptr),
        .wdata     (tracked_pc),
        .raddr_new (newest_idx),
        .rdata_new (newest_pc),
        .raddr_sel (sel_idx),
        .rdata_sel (sel_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SPC_IDLE;
            wr_ptr     <= '0;
            count      <= '0;
            sel_depth  <= '0;
            last_pc_q  <= BOOT_ADDR;
            rb_valid_o <= 1'b0;
            rb_pc_o    <= BOOT_ADDR;
            err_o      <= 1'b0;
            drop_o     <= 1'b0;
        end else begin
            err_o  <= 1'b0;
            drop_o <= 1'b0;
            if (pc_valid_i) begin
                last_pc_q <= pc_i;
            end
            case (state)
                SPC_IDLE: begin
                    if (rollback_i) begin
                        drop_o <= commit_i;
                        if (rb_legal) begin
                            state      <= SPC_ROLLBACK;
                            rb_valid_o <= 1'b1;
                            rb_pc_o    <= sel_pc;
                            sel_depth  <= rb_depth_i;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end else if (commit_i) begin
                        wr_ptr <= wr_ptr + PW'(1);
                        if (count != CW'(DEPTH)) begin
                            count <= count + CW'(1);
                        end
                    end
                end
                SPC_ROLLBACK: begin
                    drop_o <= commit_i;
                    if (rb_ack_i) begin
                        // Discarding k newer entries makes the selected one newest.
                        count      <= count - CW'(sel_depth);
                        wr_ptr     <= wr_ptr - sel_depth;
                        state      <= SPC_IDLE;
                        rb_valid_o <= 1'b0;
                    end
                end
                default: state <= SPC_IDLE;
            endcase
        end
    end

    assign spc_o   = (count == '0) ? BOOT_ADDR : newest_pc;
    assign count_o = count;
    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);

endmodule

// File: doc/spc_ring.md
Name: spc_ring

Overview:
- Parametrised successor to the single-register safe-PC block: keeps a circular history of up to DEPTH safe-PC checkpoints instead of one.
- Sits between the core fetch interface (instr_addr_o qualified by instr_req_o & instr_gnt_i) and the fault-tolerance controller.
- On a rollback request it selects the k-th newest checkpoint and presents it through a valid/ack handshake. It then discards all newer checkpoints.
- spc_o keeps the legacy single-value meaning: the newest checkpoint.

Parameters:
- ADDR_WIDTH, 32, width of PC values.
- DEPTH, 4, number of checkpoint entries; power of two, >= 2.
- BOOT_ADDR, 32'h0000_0000, value of spc_o and rb_pc_o when no checkpoint exists.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- pc_i  in  ADDR_WIDTH  fetch address from the core.
- pc_valid_i  in  1  fetch accepted (instr_req & instr_gnt); qualifies pc_i.
- commit_i  in  1  checkpoint strobe (legacy "signal").
- rollback_i  in  1  rollback request.
- rb_depth_i  in  $clog2(DEPTH)  checkpoint index for rollback; 0 = newest.
- rb_valid_o  out  1  rollback PC valid.
- rb_pc_o  out  ADDR_WIDTH  selected rollback PC.
- rb_ack_i  in  1  controller has consumed rb_pc_o.
- spc_o  out  ADDR_WIDTH  newest checkpoint, or BOOT_ADDR if empty.
- count_o  out  $clog2(DEPTH)+1  number of valid checkpoints.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- err_o  out  1  one-cycle pulse: illegal rollback.
- drop_o  out  1  one-cycle pulse: commit ignored.

Behaviour:

Reset (rst=1 on a clk edge):
- State goes to IDLE; count = 0; wr_ptr = 0; last_pc_q = BOOT_ADDR.
- Outputs: rb_valid_o = 0, rb_pc_o = BOOT_ADDR, spc_o = BOOT_ADDR, full_o = 0, empty_o = 1, err_o = 0, drop_o = 0.
- Reset asserted during ROLLBACK aborts the handshake; rb_valid_o is 0 the next cycle.

PC tracking:
- last_pc_q <= pc_i whenever pc_valid_i = 1.
- Tracked PC = pc_valid_i ? pc_i : last_pc_q (same-cycle bypass).

Commit (state IDLE, commit_i=1, rollback_i=0):
- The tracked PC is written at wr_ptr; wr_ptr increments modulo DEPTH.
- count saturates at DEPTH. When full, the oldest entry is overwritten; this is not an error and drop_o stays 0.
- spc_o, count_o, full_o and empty_o reflect the new entry on the next cycle (1-cycle latency).

Rollback request (state IDLE, rollback_i=1):
- Legal if rb_depth_i < count. Next cycle: state = ROLLBACK, rb_valid_o = 1, rb_pc_o = entry[(wr_ptr-1-rb_depth_i) mod DEPTH]; the selected index is latched.
- Illegal if rb_depth_i >= count, including the empty case: err_o pulses the next cycle, state stays IDLE, and no storage changes.
- If commit_i is also 1 in the same cycle, rollback takes priority: the commit is discarded and drop_o pulses the next cycle, whether the rollback is legal or illegal.

ROLLBACK state:
- rb_valid_o and rb_pc_o are held stable until rb_ack_i = 1.
- On the ack cycle:
  - count <= count - k, where k is the latched depth;
  - wr_ptr <= wr_ptr - k (mod DEPTH);
  - next state IDLE, rb_valid_o = 0.
- The selected entry becomes the newest, so spc_o equals the rolled-back PC from the next cycle.
- commit_i while in ROLLBACK (including the ack cycle) is ignored and drop_o pulses the next cycle.
- rollback_i while in ROLLBACK is ignored, with no err_o.
- pc_valid_i tracking continues in all states.

Wrap-around and arithmetic:
- Pointer arithmetic is modulo DEPTH using $clog2(DEPTH)-bit wrap.
- count never exceeds DEPTH and never underflows.

Decomposition:
- Package spc_pkg holds:
  - spc_state_e enum {SPC_IDLE, SPC_ROLLBACK};
  - a localparam function for pointer width;
  - the BOOT_ADDR default constant.
- One sub-module, spc_ring_mem: a DEPTH x ADDR_WIDTH register array with 1 synchronous write port and 2 asynchronous read ports (newest entry and selected entry).
- Pointers, count and the FSM stay in spc_ring.

Test Plan (DEPTH=4, BOOT_ADDR=0):
1. Reset, then commit with pc_i=0x100, pc_valid_i=1 in the same cycle. Required: next cycle spc_o=0x100, count_o=1, empty_o=0. Before the commit, spc_o=0.
2. Commit 0x10, 0x20, 0x30, 0x40, 0x50 in sequence. Required: full_o=1, count_o=4, spc_o=0x50. Rollback with depth 3 gives rb_pc_o=0x20, proving 0x10 was overwritten.
3. With entries 0x10, 0x20, 0x30, request rollback depth 1. Required: rb_valid_o=1, rb_pc_o=0x20, held stable for 3 cycles without ack. After ack: count_o=2, spc_o=0x20, rb_valid_o=0.
4. From empty, rollback depth 0. Required: err_o pulses once, state IDLE, count_o=0. With count 2, rollback depth 2 also gives err_o.
5. Raise commit_i and rollback_i (depth 0) in the same cycle with entries 0x10, 0x20. Required: drop_o=1 and rb_pc_o=0x20. A commit during ROLLBACK also pulses drop_o, and count is unchanged by it.
6. Assert rst while rb_valid_o=1. Required: next cycle rb_valid_o=0, count_o=0, spc_o=0. A subsequent ack has no effect.
